// File: rtl/elevator_timer_if.sv
// Level-request / status bundle between the elevator controller FSM and elevator_timer.
// The controller side uses the master modport, the timer the slave modport.
interface elevator_timer_if #(
  parameter int CW = 8
);
  logic          StRun;
  logic          StOpen;
  logic          delay;
  logic          obstruct;
  logic          tick;
  logic [CW-1:0] count;
  logic          endRun;
  logic          endOpen;
  logic [1:0]    dispStage;
  logic [1:0]    ext;
  logic          busy;

  modport master (
    output StRun, StOpen, delay, obstruct,
    input  tick, count, endRun, endOpen, dispStage, ext, busy
  );

  modport slave (
    input  StRun, StOpen, delay, obstruct,
    output tick, count, endRun, endOpen, dispStage, ext, busy
  );
endinterface

// File: rtl/elevator_timer.sv
// Combined travel / door timer for the elevator controller: internal tick prescaler,
// floor-transition timing, door cycle with capped hold extensions and obstruction reopen.
module elevator_timer #(
  parameter int DIV        = 8,
  parameter int RUN_TICKS  = 6,
  parameter int OPEN_TICKS = 22,
  parameter int EXT_TICKS  = 20,
  parameter int MAX_EXT    = 3,
  parameter int CW         = 8
) (
  input  logic            CP,
  input  logic            nCR,
  elevator_timer_if.slave bus
);
  localparam int PW = $clog2(DIV);

  if ((DIV < 2) || (RUN_TICKS < 2) || (OPEN_TICKS < 6) || (MAX_EXT > 3) ||
      ((2 ** CW) <= (OPEN_TICKS + MAX_EXT * EXT_TICKS))) begin : g_param_check
    $error("elevator_timer: illegal parameter set");
  end

  localparam logic [PW-1:0] PRESC_LAST   = PW'(DIV - 1);
  localparam logic [CW-1:0] RUN_LAST     = CW'(RUN_TICKS - 1);
  localparam logic [CW-1:0] COUNT_REOPEN = CW'(3);
  localparam logic [1:0]    EXT_MAX      = 2'(MAX_EXT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DOOR = 2'd2,
    DONE = 2'd3
  } state_t;

  // Door-cycle length for a given number of accepted extensions.
  function automatic logic [CW-1:0] door_limit(input logic [1:0] e);
    return CW'(OPEN_TICKS) + (CW'(EXT_TICKS) * CW'(e));
  endfunction

  state_t        state_r, state_nxt_s;
  logic [PW-1:0] presc_r, presc_nxt_s;
  logic [CW-1:0] count_r, count_nxt_s;
  logic [1:0]    ext_r, ext_nxt_s;
  logic          end_run_r, end_run_nxt_s;
  logic          end_open_r, end_open_nxt_s;
  logic          delay_q_r;

  logic          active_s;
  logic          tick_s;
  logic [CW-1:0] limit_s;
  logic          closing_s;
  logic          last_s;
  logic          delay_rise_s;
  logic          door_done_s;
  logic [1:0]    disp_s;

  assign active_s     = (state_r == RUN) || (state_r == DOOR);
  assign tick_s       = active_s && (presc_r == PRESC_LAST);
  assign limit_s      = door_limit(ext_r);
  assign closing_s    = (count_r >= (limit_s - CW'(2)));
  assign last_s       = (count_r == (limit_s - CW'(1)));
  assign delay_rise_s = bus.delay & ~delay_q_r;
  // Obstruction on the terminal tick wins: the door reopens instead of finishing.
  assign door_done_s  = (state_r == DOOR) && bus.StOpen && tick_s && last_s && !bus.obstruct;

  // State register.
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; door request wins over travel request from IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.StOpen)     state_nxt_s = DOOR;
        else if (bus.StRun) state_nxt_s = RUN;
        else                state_nxt_s = IDLE;
      end
      RUN: begin
        if (!bus.StRun) state_nxt_s = IDLE;
        else            state_nxt_s = RUN;
      end
      DOOR: begin
        if (!bus.StOpen)     state_nxt_s = IDLE;
        else if (door_done_s) state_nxt_s = DONE;
        else                 state_nxt_s = DOOR;
      end
      DONE: begin
        if (!bus.StOpen) state_nxt_s = IDLE;
        else             state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of prescaler, phase count, extensions and completion pulses.
  always_comb begin
    presc_nxt_s    = {PW{1'b0}};
    count_nxt_s    = count_r;
    ext_nxt_s      = ext_r;
    end_run_nxt_s  = 1'b0;
    end_open_nxt_s = 1'b0;
    // Prescaler only runs while staying in an active phase; any phase change restarts it.
    if (active_s && (state_nxt_s == state_r) && !tick_s) begin
      presc_nxt_s = presc_r + PW'(1);
    end else begin
      presc_nxt_s = {PW{1'b0}};
    end
    if ((state_nxt_s == IDLE) || (state_r == IDLE)) begin
      count_nxt_s = {CW{1'b0}};
      ext_nxt_s   = 2'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (tick_s && (count_r == RUN_LAST)) begin
            count_nxt_s   = {CW{1'b0}};
            end_run_nxt_s = 1'b1;
          end else if (tick_s) begin
            count_nxt_s = count_r + CW'(1);
          end else begin
            count_nxt_s = count_r;
          end
        end
        DOOR: begin
          if (door_done_s) begin
            count_nxt_s    = {CW{1'b0}};
            end_open_nxt_s = 1'b1;
          end else if (tick_s && bus.obstruct && closing_s) begin
            count_nxt_s = COUNT_REOPEN;
          end else if (tick_s) begin
            count_nxt_s = count_r + CW'(1);
          end else begin
            count_nxt_s = count_r;
          end
          if (delay_rise_s && !door_done_s && (ext_r < EXT_MAX)) begin
            ext_nxt_s = ext_r + 2'd1;
          end else begin
            ext_nxt_s = ext_r;
          end
        end
        DONE: begin
          end_open_nxt_s = 1'b1;
        end
        default: begin
          count_nxt_s = {CW{1'b0}};
        end
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      presc_r    <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      ext_r      <= 2'd0;
      end_run_r  <= 1'b0;
      end_open_r <= 1'b0;
      delay_q_r  <= 1'b0;
    end else begin
      presc_r    <= presc_nxt_s;
      count_r    <= count_nxt_s;
      ext_r      <= ext_nxt_s;
      end_run_r  <= end_run_nxt_s;
      end_open_r <= end_open_nxt_s;
      delay_q_r  <= bus.delay;
    end
  end

  // Door stage display: ramps 0..3 on opening, holds 3, ramps 2,1 while closing.
  always_comb begin
    disp_s = 2'd0;
    if (state_r == DOOR) begin
      if (count_r == (limit_s - CW'(1)))      disp_s = 2'd1;
      else if (count_r == (limit_s - CW'(2))) disp_s = 2'd2;
      else if (count_r >= COUNT_REOPEN)      disp_s = 2'd3;
      else                                   disp_s = count_r[1:0];
    end else begin
      disp_s = 2'd0;
    end
  end

  assign bus.tick      = tick_s;
  assign bus.count     = count_r;
  assign bus.endRun    = end_run_r;
  assign bus.endOpen   = end_open_r;
  assign bus.dispStage = disp_s;
  assign bus.ext       = ext_r;
  assign bus.busy      = (state_r != IDLE);

endmodule

// File: tb/tb_elevator_timer.sv
// Self-checking bench for elevator_timer: directed scenarios plus randomized travel holds
// and door cycles with random hold-button presses, checked against a timing-rule model.
module tb_elevator_timer;
  localparam int DIV = 4;
  localparam int RT  = 6;
  localparam int OT  = 22;
  localparam int ET  = 20;
  localparam int MX  = 3;
  localparam int CW  = 8;
  localparam int DOOR_BOUND = DIV * (OT + MX * ET) + 8;

  logic CP  = 1'b0;
  logic nCR = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   end_t;
  int   n;

  elevator_timer_if #(.CW(CW)) bus ();

  elevator_timer #(
    .DIV(DIV), .RUN_TICKS(RT), .OPEN_TICKS(OT), .EXT_TICKS(ET), .MAX_EXT(MX), .CW(CW)
  ) dut (
    .CP (CP),
    .nCR(nCR),
    .bus(bus)
  );

  always #5 CP = ~CP;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CP);
    #1;
  endtask

  // Expected door display for a tick count c within a cycle of length lim.
  function automatic int disp_of(input int c, input int lim);
    if (c == lim - 1) return 1;
    if (c == lim - 2) return 2;
    if (c >= 3) return 3;
    return c;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_count"}, bus.count, 0);
    chk({tag, "_tick"}, bus.tick, 0);
    chk({tag, "_endRun"}, bus.endRun, 0);
    chk({tag, "_endOpen"}, bus.endOpen, 0);
    chk({tag, "_disp"}, bus.dispStage, 0);
    chk({tag, "_ext"}, bus.ext, 0);
  endtask

  // StRun sampled high on `hold` consecutive edges, then dropped.
  task automatic run_hold(input int hold);
    bus.StRun = 1'b1;
    for (int t = 0; t < hold; t++) begin
      step();
      chk("run_endRun", bus.endRun, (t > 0) && (t % (DIV * RT) == 0));
      chk("run_count", bus.count, (t / DIV) % RT);
      chk("run_tick", bus.tick, (t % DIV) == DIV - 1);
      chk("run_busy", bus.busy, 1);
    end
    bus.StRun = 1'b0;
    step();
    chk_idle("run_exit");
  endtask

  // Door cycle with up to four 2-cycle delay pulses starting at d0..d3 (negative = none).
  task automatic door_run(input int d0, input int d1, input int d2, input int d3,
                          output int done_t);
    int  ext_m;
    int  lim;
    bit  dnow;
    bit  prev;
    ext_m  = 0;
    prev   = 1'b0;
    done_t = -1;
    bus.StOpen = 1'b1;
    for (int t = 0; (t < DOOR_BOUND) && (done_t < 0); t++) begin
      dnow = (t >= d0 && t < d0 + 2) || (t >= d1 && t < d1 + 2) ||
             (t >= d2 && t < d2 + 2) || (t >= d3 && t < d3 + 2);
      bus.delay = dnow;
      if (dnow && !prev && t > 0 && ext_m < MX && t < DIV * (OT + ext_m * ET)) ext_m++;
      prev = dnow;
      step();
      lim = OT + ext_m * ET;
      if (t == DIV * lim) begin
        done_t = t;
        chk("door_endOpen_rise", bus.endOpen, 1);
        chk("door_end_count", bus.count, 0);
        chk("door_end_disp", bus.dispStage, 0);
        chk("door_end_ext", bus.ext, ext_m);
      end else begin
        chk("door_endOpen_low", bus.endOpen, 0);
        chk("door_ext", bus.ext, ext_m);
        chk("door_disp", bus.dispStage, disp_of(t / DIV, lim));
      end
    end
    bus.delay = 1'b0;
    chk("door_timeout", done_t >= 0, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("done_hold_endOpen", bus.endOpen, done_t >= 0);
      chk("done_tick", bus.tick, 0);
      chk("done_disp", bus.dispStage, 0);
    end
    bus.StOpen = 1'b0;
    step();
    chk_idle("door_exit");
  endtask

  initial begin
    bus.StRun    = 1'b0;
    bus.StOpen   = 1'b0;
    bus.delay    = 1'b0;
    bus.obstruct = 1'b0;
    #12;
    chk_idle("reset");
    nCR = 1'b1;

    // Back-to-back floor transitions for 60 cycles.
    run_hold(60);

    // Plain door cycle and one with four hold presses (fourth beyond the cap).
    door_run(-10, -10, -10, -10, end_t);
    chk("door_basic_end_t", end_t, 88);
    door_run(10, 30, 50, 70, end_t);
    chk("door_ext_end_t", end_t, 328);

    // Obstruction: ignored while open, reopens the door on the closing tick.
    bus.StOpen = 1'b1;
    for (int t = 0; t < 88; t++) begin
      bus.obstruct = (t >= 40) && (t < 48);
      step();
    end
    chk("obs_pre_count", bus.count, 21);
    chk("obs_pre_disp", bus.dispStage, 1);
    bus.obstruct = 1'b1;
    step();
    chk("obs_count", bus.count, 3);
    chk("obs_disp", bus.dispStage, 3);
    chk("obs_endOpen", bus.endOpen, 0);
    bus.obstruct = 1'b0;
    n = 0;
    while ((bus.endOpen !== 1'b1) && (n < 200)) begin
      step();
      n++;
    end
    chk("obs_reopen_t", n, 19 * DIV);
    bus.StOpen = 1'b0;
    step();
    chk_idle("obs_exit");

    // Simultaneous requests: door wins, no travel pulses.
    bus.StRun  = 1'b1;
    bus.StOpen = 1'b1;
    for (int t = 0; t < 30; t++) begin
      step();
      chk("both_endRun", bus.endRun, 0);
      chk("both_disp", bus.dispStage, disp_of(t / DIV, OT));
    end
    bus.StRun  = 1'b0;
    bus.StOpen = 1'b0;
    step();
    chk_idle("both_exit");

    // Asynchronous reset mid-door with two extensions, then a fresh cycle.
    bus.StOpen = 1'b1;
    for (int t = 0; t < 20; t++) begin
      bus.delay = (t == 5) || (t == 6) || (t == 12) || (t == 13);
      step();
    end
    bus.delay = 1'b0;
    chk("rst_pre_ext", bus.ext, 2);
    #2 nCR = 1'b0;
    #1 chk_idle("rst_async");
    #2 nCR = 1'b1;
    step();
    chk("rst_fresh_busy", bus.busy, 1);
    chk("rst_fresh_ext", bus.ext, 0);
    chk("rst_fresh_count", bus.count, 0);
    for (int k = 0; k < 3; k++) step();
    chk("rst_fresh_tick", bus.tick, 1);
    step();
    chk("rst_fresh_disp", bus.dispStage, 1);
    bus.StOpen = 1'b0;
    step();
    chk_idle("rst_exit");

    // Randomized travel holds and door cycles with random hold presses.
    for (int r = 0; r < 6; r++) begin
      int a, b, c, d;
      run_hold(int'($urandom_range(10, 80)));
      a = int'($urandom_range(1, 60));
      b = a + int'($urandom_range(4, 100));
      c = b + int'($urandom_range(4, 100));
      d = c + int'($urandom_range(4, 100));
      door_run(a, b, c, d, end_t);
      repeat (int'($urandom_range(1, 5))) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/elevator_timer.md
# elevator_timer

Parametrised motion and door timer for the 4-storey elevator controller, replacing the separate run timer, door timer and clock divider with one block. It derives its own tick from the system clock and times floor-to-floor travel and the door cycle. Door-hold extension is accumulated and capped, and an obstruction during closing reopens the door. The controller FSM drives the level requests `StRun` / `StOpen` and consumes `endRun` / `endOpen` plus `dispStage` for the door display.

## Interface
- `DIV`, default 8: CP cycles per timer tick (≥2).
- `RUN_TICKS`, default 6: ticks per floor transition (≥2).
- `OPEN_TICKS`, default 22: base door-cycle length in ticks (≥6).
- `EXT_TICKS`, default 20: ticks added per accepted `delay` request.
- `MAX_EXT`, default 3: maximum accepted extensions per door cycle.
- `CW`, default 8: count width; elaboration error unless 2^CW > OPEN_TICKS + MAX_EXT*EXT_TICKS.
- `CP  in  1`: system clock, rising edge.
- `nCR  in  1`: asynchronous active-low reset.
- `StRun  in  1`: level request, time floor transitions.
- `StOpen  in  1`: level request, run door cycle.
- `delay  in  1`: hold-door button, level; rising edge detected internally on CP.
- `obstruct  in  1`: door-path obstruction, level.
- `tick  out  1`: one-CP pulse per prescaler period (active phases only).
- `count  out  CW`: tick count within current phase.
- `endRun  out  1`: one-CP pulse per completed floor transition.
- `endOpen  out  1`: door cycle finished; held until `StOpen` low.
- `dispStage  out  2`: door opening stage, 0 = closed, 3 = fully open.
- `ext  out  2`: extensions accepted in current door cycle.
- `busy  out  1`: state ≠ IDLE.

## Operation
- States: IDLE, RUN, DOOR, DONE. Reset: IDLE; all outputs 0, prescaler 0, delay edge register 0.
- IDLE: `StOpen`=1 → DOOR (wins when `StRun` also 1); else `StRun`=1 → RUN. Entry clears prescaler, `count`, `ext`.
- Prescaler counts 0..DIV-1 in RUN/DOOR only; `tick`=1 in the cycle prescaler==DIV-1; frozen at 0 in IDLE/DONE.
- RUN: on tick, `count`==RUN_TICKS-1 → `count`←0, `endRun`←1 for one cycle; else `count`+1. Stays in RUN while `StRun`=1 (back-to-back floors). `StRun`=0 → IDLE next edge, `count`←0, no `endRun`.
- DOOR: limit L = OPEN_TICKS + `ext`*EXT_TICKS, re-evaluated every cycle. On tick, `count`+1; tick with `count`==L-1 → DONE, `endOpen`←1, `count`←0.
- `dispStage`, combinational from `count`/L in DOOR: `count` 0→0, 1→1, 2→2, 3..L-3→3, L-2→2, L-1→1; 0 outside DOOR.
- `delay` rising edge in DOOR: `ext`<MAX_EXT → `ext`+1; else ignored. Edges outside DOOR ignored.
- Closing: `count`≥L-2. `obstruct`=1 on a tick while closing → `count`←3 (fully open); no `endOpen` that tick. Obstruct takes priority over the terminal transition.
- `StOpen`=0 in DOOR → IDLE immediately (abort); no `endOpen`.
- DONE: `endOpen`=1, `dispStage`=0. `StOpen`=0 → IDLE, `endOpen`←0, `ext`←0. A new cycle needs `StOpen` to fall and rise again.
- `nCR` low at any time: immediate return to reset state, regardless of phase.

## Timing
- Request sampled at CP edge k; state valid k+1; first `tick` at cycle k+DIV.
- First `endRun` DIV*RUN_TICKS cycles after RUN entry; then every DIV*RUN_TICKS while `StRun` held.
- `endOpen` rises DIV*L cycles after DOOR entry, absent obstruction; each accepted extension adds DIV*EXT_TICKS.
- A `delay` edge coinciding with the terminal tick is not counted; DONE is taken.
- All outputs registered except `dispStage`, `busy` and `tick` (decoded from registers; glitch-free at CP edges).

## Test plan
- DIV=4, RUN_TICKS=6, `StRun` held 60 cycles → `endRun` pulses at cycles 24 and 48 after entry, `count` wraps 5→0; drop `StRun` → IDLE, `count`=0.
- DIV=4, OPEN_TICKS=22, `StOpen` pulse-held → `dispStage` sequence 0,1,2,3…3,2,1; `endOpen` at cycle 88; stays 1 until `StOpen`=0.
- Four `delay` edges during DOOR (MAX_EXT=3) → `ext`=3, fourth ignored; `endOpen` at cycle 4*(22+60)=328.
- `obstruct`=1 while `count`=21 (L=22) → `count`=3, `dispStage`=3; release → `endOpen` 19 ticks later.
- `StRun`=`StOpen`=1 simultaneously from IDLE → DOOR entered, no `tick`-driven RUN activity.
- `nCR` pulsed low mid-DOOR with `ext`=2 → all outputs 0 asynchronously, IDLE. `StOpen` still high after release → fresh cycle, `ext`=0.
